cpu_seq_ctrl: RTL and testbench

- Top-level fetch/decode/execute sequencer for the 8-bit CPU.
- Fetches instructions over a req/ack memory handshake and holds the current instruction in an instruction register.
- The instruction register feeds the instruction decoder; this block pulses the ALU enable and register-file write strobes, and updates the PC for sequential flow and branches.
- Sits between the instruction memory port and the decoder/ALU/register file.

---
 rtl/cpu_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl -- fetch/decode/execute sequencer for the 8-bit CPU.
//
// Fetches one instruction at a time over a req/ack memory port and latches it
// into the instruction register. The opcode (insn[7:4]) then selects one of
// these paths:
//   NOP             : DECODE -> FETCH
//   ALU (0x1..0xB)  : DECODE -> EXEC (alu_en) -> WB (reg_we, wb_sel=0) -> FETCH
//   LDI (0xC)       : DECODE -> WB (reg_we, wb_sel=1) -> FETCH
//   BZ / JMP        : relative branch on the already-incremented pc -> FETCH
//   HALT            : stop until reset
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 begin execution (sampled in IDLE only)
//   mem_req/addr/ack/rdata instruction fetch handshake
//   zero_flag             ALU zero flag, used by BZ
//   insn                  instruction register output to the decoder
//   alu_en, reg_we        one-cycle execute / register write strobes
//   wb_sel                writeback source: 0=ALU, 1=immediate
//   pc                    program counter
//   busy, halted, fault   status
//
// Optional build macro CTRL_TIMEOUT_EN: adds a fetch wait counter. A fetch
// with no ack for TIMEOUT wait cycles sets the sticky fault and halts.
// Without the macro FETCH waits forever and fault stays 0.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | mem_req high with mem_addr=pc, waiting for mem_ack
// DECODE | opcode dispatch, branch target computed here
// EXEC   | alu_en pulse
// WB     | reg_we pulse
// HALT   | halted; only reset leaves this state

module cpu_seq_ctrl #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            mem_req,
   output logic [PC_W-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [7:0]      mem_rdata,
   input  logic            zero_flag,
   output logic [7:0]      insn,
   output logic            alu_en,
   output logic            reg_we,
   output logic            wb_sel,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic            fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [7:0]      insn_q;
   logic            mem_req_q;
   logic            alu_en_q;
   logic            reg_we_q;
   logic            wb_sel_q;
   logic            busy_q;
   logic            halted_q;
   logic            fault_q;

   logic [3:0]      opcode;
   logic [PC_W-1:0] offset;
   logic            fetch_timeout;

   assign opcode = insn_q[7:4];
   assign offset = {{(PC_W-4){insn_q[3]}}, insn_q[3:0]};

`ifdef CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_q;

   // Every FETCH is preceded by a non-FETCH state, so holding the counter at
   // zero outside FETCH clears it on each FETCH entry. An ack in the cycle
   // the count sits at TIMEOUT still wins over the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
      end else if (state_q == S_FETCH && !mem_ack) begin
         wait_q <= wait_q + CNT_W'(1);
      end else begin
         wait_q <= '0;
      end
   end

   assign fetch_timeout = (state_q == S_FETCH) && !mem_ack && (wait_q == CNT_W'(TIMEOUT));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign fetch_timeout  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         insn_q    <= '0;
         mem_req_q <= 1'b0;
         alu_en_q  <= 1'b0;
         reg_we_q  <= 1'b0;
         wb_sel_q  <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         alu_en_q <= 1'b0;
         reg_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_FETCH;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  insn_q    <= mem_rdata;
                  pc_q      <= pc_q + PC_W'(1);
                  mem_req_q <= 1'b0;
                  state_q   <= S_DECODE;
               end else if (fetch_timeout) begin
                  fault_q   <= 1'b1;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  halted_q  <= 1'b1;
                  state_q   <= S_HALT;
               end
            end
            S_DECODE: begin
               case (opcode)
                  4'h0: begin
                     mem_req_q <= 1'b1;
                     state_q   <= S_FETCH;
                  end
                  4'hC: begin
                     reg_we_q <= 1'b1;
                     wb_sel_q <= 1'b1;
                     state_q  <= S_WB;
                  end
                  4'hD: begin
                     if (zero_flag) begin
                        pc_q <= pc_q + offset;
                     end
                     mem_req_q <= 1'b1;
                     state_q   <= S_FETCH;
                  end
                  4'hE: begin
                     pc_q      <= pc_q + offset;
                     mem_req_q <= 1'b1;
                     state_q   <= S_FETCH;
                  end
                  4'hF: begin
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                     state_q  <= S_HALT;
                  end
                  default: begin
                     alu_en_q <= 1'b1;
                     state_q  <= S_EXEC;
                  end
               endcase
            end
            S_EXEC: begin
               reg_we_q <= 1'b1;
               wb_sel_q <= 1'b0;
               state_q  <= S_WB;
            end
            S_WB: begin
               mem_req_q <= 1'b1;
               state_q   <= S_FETCH;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign insn     = insn_q;
   assign alu_en   = alu_en_q;
   assign reg_we   = reg_we_q;
   assign wb_sel   = wb_sel_q;
   assign pc       = pc_q;
   assign busy     = busy_q;
   assign halted   = halted_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: table of single-instruction programs plus
// hand-written sequences for reset, stalls and fetch timeout.
// Each table program is: addr 0 = JMP to the instruction under test,
// instruction under test, and HALT everywhere else, so the fetch after the
// instruction under test reveals its next-address behaviour.
module tb_cpu_seq_ctrl;
   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            mem_ack = 1'b0;
   logic [7:0]      mem_rdata = 8'h00;
   logic            zero_flag = 1'b0;
   logic            mem_req, alu_en, reg_we, wb_sel, busy, halted, fault;
   logic [PC_W-1:0] mem_addr, pc;
   logic [7:0]      insn;

   cpu_seq_ctrl #(.PC_W(PC_W), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .zero_flag(zero_flag), .insn(insn), .alu_en(alu_en), .reg_we(reg_we),
      .wb_sel(wb_sel), .pc(pc), .busy(busy), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // memory responder and monitor (everything sampled/driven at negedge)
   logic [7:0]      mem [256];
   int              ack_delay = 0;
   bit              ack_never = 0;
   bit              ack_force = 0;
   int              cyc = 0;
   int              run_len = 0;
   int              alu_cnt = 0;
   int              we_cnt = 0;
   bit              last_wbsel = 0;
   bit              prev_req = 0;
   logic [PC_W-1:0] prev_addr = '0;
   bit              acked_last = 0;
   int              fetch_addr[$];
   int              fetch_cyc[$];
   int              fetch_run[$];
   int              fetch_insn[$];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (acked_last) fetch_insn.push_back(int'(insn));
         acked_last = 0;
         if (alu_en) alu_cnt++;
         if (reg_we) begin
            we_cnt++;
            last_wbsel = wb_sel;
         end
         if (mem_req) begin
            if (prev_req && mem_addr == prev_addr) run_len++;
            else run_len = 1;
         end else begin
            run_len = 0;
         end
         prev_req  = mem_req;
         prev_addr = mem_addr;
         if (mem_req && !ack_never && run_len == ack_delay + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            fetch_addr.push_back(int'(mem_addr));
            fetch_cyc.push_back(cyc);
            fetch_run.push_back(run_len);
            acked_last = 1;
         end else begin
            mem_ack   = ack_force;
            mem_rdata = ack_force ? 8'hAA : 8'h00;
         end
      end
   end

   task automatic reset_dut();
      rst_n = 1'b0;
      start = 1'b0;
      ack_never = 0;
      ack_force = 0;
      ack_delay = 0;
      zero_flag = 1'b0;
      @(posedge clk); #1;
      fetch_addr.delete();
      fetch_cyc.delete();
      fetch_run.delete();
      fetch_insn.delete();
      alu_cnt = 0;
      we_cnt = 0;
      last_wbsel = 0;
      acked_last = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // start is sampled by the DUT on the posedge this task waits for
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_halted(input int max_cyc, output bit ok);
      ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         if (halted) begin
            ok = 1;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] op;
      bit         zf;
      int         dly;
      logic [7:0] nxt;
      int         alu;
      int         we;
      bit         wbs;
      int         lat;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   initial begin
      bit         ok;
      logic [7:0] off;
      logic [7:0] exp_pc;

      // addr, op, zf, delay, next fetch, alu pulses, we pulses, wb_sel, ack-to-ack cycles
      vecs[0] = '{8'h01, 8'h00, 1'b0, 0, 8'h02, 0, 0, 1'b0, 2};
      vecs[1] = '{8'h03, 8'h35, 1'b0, 2, 8'h04, 1, 1, 1'b0, 6};
      vecs[2] = '{8'h08, 8'hC7, 1'b0, 0, 8'h09, 0, 1, 1'b1, 3};
      vecs[3] = '{8'h05, 8'hDE, 1'b1, 0, 8'h04, 0, 0, 1'b0, 2};
      vecs[4] = '{8'h05, 8'hDE, 1'b0, 0, 8'h06, 0, 0, 1'b0, 2};
      vecs[5] = '{8'hFA, 8'hE7, 1'b0, 0, 8'h02, 0, 0, 1'b0, 2};
      vecs[6] = '{8'hF9, 8'hB1, 1'b1, 1, 8'hFA, 1, 1, 1'b0, 5};
      vecs[7] = '{8'h02, 8'hD7, 1'b1, 1, 8'h0A, 0, 0, 1'b0, 3};
      vecs[8] = '{8'h06, 8'hE8, 1'b0, 0, 8'hFF, 0, 0, 1'b0, 2};
      vecs[9] = '{8'h04, 8'h1F, 1'b0, 0, 8'h05, 1, 1, 1'b0, 4};

      // reset values
      #1;
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_alu_en", int'(alu_en), 0);
      chk("rst_reg_we", int'(reg_we), 0);
      chk("rst_wb_sel", int'(wb_sel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_insn", int'(insn), 0);

      // NOP then HALT, zero-wait
      for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
      mem[0] = 8'h00;
      reset_dut();
      // ack outside FETCH is ignored
      ack_force = 1;
      repeat (3) @(posedge clk);
      #1;
      ack_force = 0;
      chk("idle_ack_insn", int'(insn), 0);
      chk("idle_ack_pc", int'(pc), 0);
      chk("idle_ack_busy", int'(busy), 0);
      pulse_start();
      chk("nop_busy", int'(busy), 1);
      chk("nop_req", int'(mem_req), 1);
      chk("nop_addr0", int'(mem_addr), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("nop_not_halted_yet", int'(halted), 0);
      @(posedge clk); #1;
      chk("nop_halted", int'(halted), 1);
      chk("nop_busy_halt", int'(busy), 0);
      chk("nop_pc", int'(pc), 2);
      chk("nop_fetches", fetch_addr.size(), 2);
      if (fetch_addr.size() == 2) begin
         chk("nop_fetch0", fetch_addr[0], 0);
         chk("nop_fetch1", fetch_addr[1], 1);
      end
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      chk("halt_start_ignored", int'(halted), 1);
      chk("halt_pc_kept", int'(pc), 2);
      chk("nop_alu_cnt", alu_cnt, 0);
      chk("nop_we_cnt", we_cnt, 0);

      // table-driven single-instruction programs
      for (int v = 0; v < NV; v++) begin
         for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
         off = vecs[v].addr - 8'd1;
         mem[0] = {4'hE, off[3:0]};
         mem[vecs[v].addr] = vecs[v].op;
         reset_dut();
         ack_delay = vecs[v].dly;
         zero_flag = vecs[v].zf;
         pulse_start();
         wait_halted(100, ok);
         chk($sformatf("v%0d_halt_reached", v), int'(ok), 1);
         chk($sformatf("v%0d_fetch_count", v), fetch_addr.size(), 3);
         if (fetch_addr.size() >= 3 && fetch_insn.size() >= 2) begin
            chk($sformatf("v%0d_prefix_addr", v), fetch_addr[0], 0);
            chk($sformatf("v%0d_addr", v), fetch_addr[1], int'(vecs[v].addr));
            chk($sformatf("v%0d_next_addr", v), fetch_addr[2], int'(vecs[v].nxt));
            chk($sformatf("v%0d_insn", v), fetch_insn[1], int'(vecs[v].op));
            chk($sformatf("v%0d_req_stable", v), fetch_run[1], vecs[v].dly + 1);
            chk($sformatf("v%0d_latency", v), fetch_cyc[2] - fetch_cyc[1], vecs[v].lat);
         end
         chk($sformatf("v%0d_alu_pulses", v), alu_cnt, vecs[v].alu);
         chk($sformatf("v%0d_we_pulses", v), we_cnt, vecs[v].we);
         if (vecs[v].we > 0) chk($sformatf("v%0d_wb_sel", v), int'(last_wbsel), int'(vecs[v].wbs));
         exp_pc = vecs[v].nxt + 8'd1;
         chk($sformatf("v%0d_pc", v), int'(pc), int'(exp_pc));
         chk($sformatf("v%0d_req_low", v), int'(mem_req), 0);
         chk($sformatf("v%0d_fault", v), int'(fault), 0);
      end

      // reset asserted during WB of an ALU instruction
      for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
      mem[0] = 8'h35;
      reset_dut();
      pulse_start();
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (reg_we) begin
            ok = 1;
            break;
         end
      end
      chk("wb_reached", int'(ok), 1);
      rst_n = 1'b0;
      #1;
      chk("wb_rst_reg_we", int'(reg_we), 0);
      chk("wb_rst_busy", int'(busy), 0);
      chk("wb_rst_pc", int'(pc), 0);
      chk("wb_rst_insn", int'(insn), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("wb_rst_no_we", we_cnt, 0);
      chk("wb_rst_alu_once", alu_cnt, 1);
      chk("wb_rst_idle_req", int'(mem_req), 0);
      chk("wb_rst_idle_busy", int'(busy), 0);

      // reset asserted during a stalled FETCH
      reset_dut();
      ack_never = 1;
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      chk("fetch_stall_req", int'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      chk("fetch_rst_req", int'(mem_req), 0);
      chk("fetch_rst_busy", int'(busy), 0);
      chk("fetch_rst_pc", int'(pc), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("fetch_rst_no_fetch", fetch_addr.size(), 0);

`ifdef CTRL_TIMEOUT_EN
      // no ack at all: 16 FETCH cycles (count 0..15), fault on the 17th edge
      reset_dut();
      ack_never = 1;
      pulse_start();
      repeat (15) @(posedge clk);
      #1;
      chk("to_no_fault_yet", int'(fault), 0);
      chk("to_req_still", int'(mem_req), 1);
      @(posedge clk); #1;
      chk("to_fault", int'(fault), 1);
      chk("to_halted", int'(halted), 1);
      chk("to_req_drop", int'(mem_req), 0);
      chk("to_pc", int'(pc), 0);
      // ack in the cycle the count reaches TIMEOUT wins
      for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
      reset_dut();
      ack_delay = 15;
      pulse_start();
      wait_halted(40, ok);
      chk("to_late_halt", int'(ok), 1);
      chk("to_late_fault", int'(fault), 0);
      chk("to_late_pc", int'(pc), 1);
      chk("to_late_fetches", fetch_addr.size(), 1);
`else
      // no timeout: FETCH waits indefinitely
      reset_dut();
      ack_never = 1;
      pulse_start();
      repeat (40) @(posedge clk);
      #1;
      chk("wait_req", int'(mem_req), 1);
      chk("wait_addr", int'(mem_addr), 0);
      chk("wait_fault", int'(fault), 0);
      chk("wait_busy", int'(busy), 1);
      chk("wait_halted", int'(halted), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
